// File: rtl/matvec_mac_sequencer_if.sv
// Matrix/vector memory read bus plus result stream for matvec_mac_sequencer.
//
// master (sequencer side):
//   rd_en      out  read strobe to both memories
//   a_rd_addr  out  row-major matrix address
//   x_rd_addr  out  vector address
//   a_rd_data  in   matrix data, valid RD_LATENCY cycles after rd_en
//   x_rd_data  in   vector data, valid RD_LATENCY cycles after rd_en
//   y_data     out  row result
//   y_index    out  row number of y_data
//   y_valid    out  result valid
//   y_ready    in   consumer accepts the result
// slave is the mirror image (memories + result consumer).
interface matvec_mac_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int MAX_ROWS   = 64,
  parameter int MAX_COLS   = 64
);
  localparam int ROW_W = $clog2(MAX_ROWS + 1);
  localparam int A_AW  = $clog2(MAX_ROWS * MAX_COLS);
  localparam int X_AW  = $clog2(MAX_COLS);

  logic                  rd_en;
  logic [A_AW-1:0]       a_rd_addr;
  logic [X_AW-1:0]       x_rd_addr;
  logic [DATA_WIDTH-1:0] a_rd_data;
  logic [DATA_WIDTH-1:0] x_rd_data;
  logic [ACC_WIDTH-1:0]  y_data;
  logic [ROW_W-1:0]      y_index;
  logic                  y_valid;
  logic                  y_ready;

  modport master (
    output rd_en, a_rd_addr, x_rd_addr,
    input  a_rd_data, x_rd_data,
    output y_data, y_index, y_valid,
    input  y_ready
  );

  modport slave (
    input  rd_en, a_rd_addr, x_rd_addr,
    output a_rd_data, x_rd_data,
    input  y_data, y_index, y_valid,
    output y_ready
  );
endinterface

// File: rtl/matvec_mac_sequencer.sv
// Matrix-vector multiply sequencer: y[i] = sum_k A[i][k] * x[k].
// Walks a runtime num_rows x num_cols row-major matrix held in an external
// RAM, multiplies against an external vector RAM, accumulates signed
// products and hands out one result per row over a valid/ready handshake.
//
// Ports:
//   clk       in   clock
//   reset_n   in   asynchronous active-low reset
//   start     in   one-cycle start request, sampled only while idle
//   num_rows  in   row count, latched on accepted start
//   num_cols  in   column count, latched on accepted start
//   busy      out  high whenever the FSM is not idle
//   done      out  one-cycle completion pulse
//   bus       matvec_mac_sequencer_if.master (memory reads + result stream)
//
// Build option: define MATVEC_MAC_SATURATE_EN to saturate every accumulate
// to the signed ACC_WIDTH range; otherwise the accumulator wraps.
module matvec_mac_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int MAX_ROWS   = 64,
  parameter int MAX_COLS   = 64,
  parameter int RD_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [$clog2(MAX_ROWS+1)-1:0]   num_rows,
  input  logic [$clog2(MAX_COLS+1)-1:0]   num_cols,
  output logic                            busy,
  output logic                            done,
  matvec_mac_sequencer_if.master          bus
);
  localparam int ROW_W = $clog2(MAX_ROWS + 1);
  localparam int COL_W = $clog2(MAX_COLS + 1);
  localparam int A_AW  = $clog2(MAX_ROWS * MAX_COLS);
  localparam int X_AW  = $clog2(MAX_COLS);
  localparam int DRN_W = $clog2(RD_LATENCY + 2);

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_ISSUE  = 5'b00010,
    S_DRAIN  = 5'b00100,
    S_OUTPUT = 5'b01000,
    S_DONE   = 5'b10000
  } state_t;

  state_t state_q, state_d;

  logic [ROW_W-1:0] rows_q, rows_d;
  logic [COL_W-1:0] cols_q, cols_d;
  logic [ROW_W-1:0] i_q, i_d;
  logic [COL_W-1:0] k_q, k_d;
  logic [A_AW-1:0]  a_cnt_q, a_cnt_d;
  logic [DRN_W-1:0] drn_q, drn_d;

  logic                 rd_en_q, rd_en_d;
  logic                 first_q, first_d;
  logic [A_AW-1:0]      a_rd_addr_q, a_rd_addr_d;
  logic [X_AW-1:0]      x_rd_addr_q, x_rd_addr_d;
  logic [ACC_WIDTH-1:0] y_data_q, y_data_d;
  logic [ROW_W-1:0]     y_index_q, y_index_d;
  logic                 y_valid_q, y_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY-1:0] first_pipe_q, first_pipe_d;

  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    sum;

`ifdef MATVEC_MAC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH:0] sum_ext;
`endif

  // Read-valid delay line and accumulator. The "first" tag rides alongside
  // the valid so the first product of a row overwrites the accumulator.
  always_comb begin
    vld_pipe_d      = '0;
    first_pipe_d    = '0;
    vld_pipe_d[0]   = rd_en_q;
    first_pipe_d[0] = first_q;
    for (int unsigned s = 1; s < RD_LATENCY; s++) begin
      vld_pipe_d[s]   = vld_pipe_q[s-1];
      first_pipe_d[s] = first_pipe_q[s-1];
    end

    prod     = $signed(bus.a_rd_data) * $signed(bus.x_rd_data);
    prod_ext = ACC_WIDTH'(prod);

`ifdef MATVEC_MAC_SATURATE_EN
    sum_ext = {acc_q[ACC_WIDTH-1], acc_q} + {prod_ext[ACC_WIDTH-1], prod_ext};
    if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) begin
      sum = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      sum = sum_ext[ACC_WIDTH-1:0];
    end
`else
    sum = acc_q + prod_ext;
`endif

    acc_d = acc_q;
    if (vld_pipe_q[RD_LATENCY-1]) begin
      acc_d = first_pipe_q[RD_LATENCY-1] ? prod_ext : sum;
    end
  end

  // Control. Read strobe and addresses are registered from the ISSUE state,
  // so they trail the FSM by one cycle; DRAIN therefore lasts RD_LATENCY+1
  // cycles so that y_valid rises RD_LATENCY+1 cycles after the last rd_en.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    i_d         = i_q;
    k_d         = k_q;
    a_cnt_d     = a_cnt_q;
    drn_d       = drn_q;
    rd_en_d     = 1'b0;
    first_d     = 1'b0;
    a_rd_addr_d = a_rd_addr_q;
    x_rd_addr_d = x_rd_addr_q;
    y_data_d    = y_data_q;
    y_index_d   = y_index_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((num_rows != '0) && (num_cols != '0)) begin
            rows_d      = num_rows;
            cols_d      = num_cols;
            i_d         = '0;
            k_d         = '0;
            a_cnt_d     = '0;
            a_rd_addr_d = '0;
            state_d     = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        rd_en_d     = 1'b1;
        first_d     = (k_q == '0);
        a_rd_addr_d = a_cnt_q;
        x_rd_addr_d = k_q[X_AW-1:0];
        a_cnt_d     = a_cnt_q + A_AW'(1);
        if (k_q == cols_q - COL_W'(1)) begin
          k_d     = '0;
          drn_d   = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + COL_W'(1);
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_W'(RD_LATENCY)) begin
          state_d   = S_OUTPUT;
          y_data_d  = acc_d;
          y_index_d = i_q;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      S_OUTPUT: begin
        if (bus.y_ready) begin
          if (i_q == rows_q - ROW_W'(1)) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q + ROW_W'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    y_valid_d = (state_d == S_OUTPUT);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rows_q       <= '0;
      cols_q       <= '0;
      i_q          <= '0;
      k_q          <= '0;
      a_cnt_q      <= '0;
      drn_q        <= '0;
      rd_en_q      <= 1'b0;
      first_q      <= 1'b0;
      a_rd_addr_q  <= '0;
      x_rd_addr_q  <= '0;
      y_data_q     <= '0;
      y_index_q    <= '0;
      y_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      i_q          <= i_d;
      k_q          <= k_d;
      a_cnt_q      <= a_cnt_d;
      drn_q        <= drn_d;
      rd_en_q      <= rd_en_d;
      first_q      <= first_d;
      a_rd_addr_q  <= a_rd_addr_d;
      x_rd_addr_q  <= x_rd_addr_d;
      y_data_q     <= y_data_d;
      y_index_q    <= y_index_d;
      y_valid_q    <= y_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      vld_pipe_q   <= vld_pipe_d;
      first_pipe_q <= first_pipe_d;
      acc_q        <= acc_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.a_rd_addr = a_rd_addr_q;
  assign bus.x_rd_addr = x_rd_addr_q;
  assign bus.y_data    = y_data_q;
  assign bus.y_index   = y_index_q;
  assign bus.y_valid   = y_valid_q;
endmodule

// File: tb/tb_matvec_mac_sequencer.sv
module tb_matvec_mac_sequencer;
  localparam int RDL = 2;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [6:0] num_rows;
  logic [6:0] num_cols;
  logic       busy;
  logic       done;

  logic       start8;
  logic [6:0] num_rows8;
  logic [6:0] num_cols8;
  logic       busy8;
  logic       done8;

  matvec_mac_sequencer_if #(.DATA_WIDTH(16), .ACC_WIDTH(40), .MAX_ROWS(64), .MAX_COLS(64)) bus ();
  matvec_mac_sequencer_if #(.DATA_WIDTH(8),  .ACC_WIDTH(16), .MAX_ROWS(64), .MAX_COLS(64)) bus8 ();

  matvec_mac_sequencer #(
    .DATA_WIDTH(16), .ACC_WIDTH(40), .MAX_ROWS(64), .MAX_COLS(64), .RD_LATENCY(RDL)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_rows(num_rows),
    .num_cols(num_cols), .busy(busy), .done(done), .bus(bus)
  );

  matvec_mac_sequencer #(
    .DATA_WIDTH(8), .ACC_WIDTH(16), .MAX_ROWS(64), .MAX_COLS(64), .RD_LATENCY(RDL)
  ) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .num_rows(num_rows8),
    .num_cols(num_cols8), .busy(busy8), .done(done8), .bus(bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: fixed RDL-cycle read latency, junk on the bus when idle.
  logic [15:0] amem [0:63];
  logic [15:0] xmem [0:63];
  logic [15:0] a_pipe [RDL];
  logic [15:0] x_pipe [RDL];
  logic        v_pipe [RDL];

  always @(posedge clk) begin
    v_pipe[0] <= bus.rd_en;
    a_pipe[0] <= amem[bus.a_rd_addr[5:0]];
    x_pipe[0] <= xmem[bus.x_rd_addr];
    for (int s = 1; s < RDL; s++) begin
      v_pipe[s] <= v_pipe[s-1];
      a_pipe[s] <= a_pipe[s-1];
      x_pipe[s] <= x_pipe[s-1];
    end
  end
  assign bus.a_rd_data = v_pipe[RDL-1] ? a_pipe[RDL-1] : 16'h5A5A;
  assign bus.x_rd_data = v_pipe[RDL-1] ? x_pipe[RDL-1] : 16'hA5A5;

  assign bus8.a_rd_data = 8'h80;
  assign bus8.x_rd_data = 8'h80;

  // Cycle counter and passive monitor (sampled on the falling edge).
  int     cyc;
  longint a_q [$];
  longint x_q [$];
  int     rd_cyc [$];
  int     yrise_q [$];
  longint yd_q [$];
  longint yi_q [$];
  int     done_cnt;
  bit     yv_prev;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rd_en) begin
      a_q.push_back(longint'(bus.a_rd_addr));
      x_q.push_back(longint'(bus.x_rd_addr));
      rd_cyc.push_back(cyc);
    end
    if (bus.y_valid && !yv_prev) yrise_q.push_back(cyc);
    if (bus.y_valid && bus.y_ready) begin
      yd_q.push_back(longint'($signed(bus.y_data)));
      yi_q.push_back(longint'(bus.y_index));
    end
    if (done) done_cnt = done_cnt + 1;
    yv_prev = bus.y_valid;
  end

  int n_cmp;
  int n_bad;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    a_q.delete(); x_q.delete(); rd_cyc.delete(); yrise_q.delete();
    yd_q.delete(); yi_q.delete();
    done_cnt = 0;
  endtask

  typedef struct {
    string  name;
    int     rows;
    int     cols;
    int     a [6];
    int     x [3];
    longint y [3];
  } vec_t;

  task automatic load(input vec_t v);
    for (int n = 0; n < 6; n++) amem[n] = 16'(v.a[n]);
    for (int n = 0; n < 3; n++) xmem[n] = 16'(v.x[n]);
  endtask

  task automatic wait_done(input string nm);
    int guard;
    guard = 0;
    while (done_cnt == 0 && guard < 400) begin
      step();
      guard++;
    end
    chk({nm, "_done_timeout"}, longint'(guard < 400), 1);
    repeat (3) step();
  endtask

  task automatic run_job(input vec_t v);
    int nres;
    load(v);
    clear_mon();
    bus.y_ready = 1'b1;
    start    = 1'b1;
    num_rows = 7'(v.rows);
    num_cols = 7'(v.cols);
    step();
    // Dimensions are latched; scribble over them while the job runs.
    start    = 1'b0;
    num_rows = 7'd0;
    num_cols = 7'd5;
    wait_done(v.name);

    chk({v.name, "_nresults"}, longint'(yd_q.size()), longint'(v.rows));
    nres = (yd_q.size() < v.rows) ? yd_q.size() : v.rows;
    for (int r = 0; r < nres; r++) begin
      chk($sformatf("%s_y%0d", v.name, r), yd_q[r], v.y[r]);
      chk($sformatf("%s_yidx%0d", v.name, r), yi_q[r], longint'(r));
    end
    chk({v.name, "_nreads"}, longint'(a_q.size()), longint'(v.rows * v.cols));
    if (a_q.size() == v.rows * v.cols) begin
      for (int n = 0; n < v.rows * v.cols; n++) begin
        chk($sformatf("%s_aaddr%0d", v.name, n), a_q[n], longint'(n));
        chk($sformatf("%s_xaddr%0d", v.name, n), x_q[n], longint'(n % v.cols));
      end
    end
    if (yrise_q.size() > 0 && rd_cyc.size() >= v.cols)
      chk({v.name, "_latency"}, longint'(yrise_q[0] - rd_cyc[v.cols-1]), longint'(RDL + 1));
    if (v.rows > 1 && yrise_q.size() > 1)
      chk({v.name, "_row_period"}, longint'(yrise_q[1] - yrise_q[0]), longint'(v.cols + RDL + 2));
    chk({v.name, "_done_pulses"}, longint'(done_cnt), 1);
    chk({v.name, "_busy_after"}, longint'(busy), 0);
  endtask

  vec_t vecs [5];
  vec_t c1;

  initial begin
    int guard;
    n_cmp = 0; n_bad = 0; cyc = 0; done_cnt = 0; yv_prev = 1'b0;
    reset_n = 1'b0;
    start = 1'b0; num_rows = '0; num_cols = '0;
    start8 = 1'b0; num_rows8 = '0; num_cols8 = '0;
    bus.y_ready = 1'b1;
    bus8.y_ready = 1'b1;
    for (int n = 0; n < 64; n++) begin amem[n] = '0; xmem[n] = '0; end

    vecs[0] = '{name:"c1",      rows:2, cols:3, a:'{1,2,3,4,5,6},            x:'{1,1,2},     y:'{9,21,0}};
    vecs[1] = '{name:"c2",      rows:1, cols:2, a:'{-3,7,0,0,0,0},           x:'{5,-2,0},    y:'{-29,0,0}};
    vecs[2] = '{name:"cols1",   rows:3, cols:1, a:'{7,-2,100,0,0,0},         x:'{-3,0,0},    y:'{-21,6,-300}};
    vecs[3] = '{name:"extreme", rows:1, cols:2, a:'{32767,-32768,0,0,0,0},   x:'{32767,-32768,0}, y:'{2147418113,0,0}};
    vecs[4] = '{name:"r3c2",    rows:3, cols:2, a:'{2,-4,0,0,-100,50},       x:'{10,3,0},    y:'{8,0,-850}};
    c1 = vecs[0];

    // Reset state
    step(); step();
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_rd_en", longint'(bus.rd_en), 0);
    chk("rst_y_valid", longint'(bus.y_valid), 0);
    chk("rst_a_addr", longint'(bus.a_rd_addr), 0);
    chk("rst_x_addr", longint'(bus.x_rd_addr), 0);
    chk("rst_y_data", longint'(bus.y_data), 0);
    chk("rst_y_index", longint'(bus.y_index), 0);
    reset_n = 1'b1;
    step();

    // Table-driven jobs
    for (int t = 0; t < 5; t++) run_job(vecs[t]);

    // Back-pressure: hold y_ready low for 5 cycles during row 0
    load(c1);
    clear_mon();
    bus.y_ready = 1'b0;
    start = 1'b1; num_rows = 7'd2; num_cols = 7'd3;
    step();
    start = 1'b0;
    guard = 0;
    while (!bus.y_valid && guard < 100) begin @(negedge clk); guard++; end
    chk("bp_wait_valid", longint'(guard < 100), 1);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp_hold_valid%0d", j), longint'(bus.y_valid), 1);
      chk($sformatf("bp_hold_data%0d", j), longint'($signed(bus.y_data)), 9);
      chk($sformatf("bp_hold_rd_en%0d", j), longint'(bus.rd_en), 0);
      if (j < 4) @(negedge clk);
    end
    step();
    bus.y_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", longint'(bus.y_valid), 1);
    @(negedge clk);
    chk("bp_after_hs_valid", longint'(bus.y_valid), 0);
    chk("bp_after_hs_busy", longint'(busy), 1);
    @(negedge clk);
    chk("bp_row1_rd_en", longint'(bus.rd_en), 1);
    chk("bp_row1_aaddr", longint'(bus.a_rd_addr), 3);
    chk("bp_row1_xaddr", longint'(bus.x_rd_addr), 0);
    step();
    wait_done("bp");
    chk("bp_nresults", longint'(yd_q.size()), 2);
    if (yd_q.size() == 2) chk("bp_y1", yd_q[1], 21);

    // Zero dimensions: immediate done, no reads, no results
    for (int z = 0; z < 2; z++) begin
      clear_mon();
      start = 1'b1;
      num_rows = (z == 0) ? 7'd0 : 7'd2;
      num_cols = (z == 0) ? 7'd4 : 7'd0;
      step();
      start = 1'b0;
      chk($sformatf("zero%0d_done", z), longint'(done), 1);
      step();
      chk($sformatf("zero%0d_done_clr", z), longint'(done), 0);
      chk($sformatf("zero%0d_busy", z), longint'(busy), 0);
      repeat (4) step();
      chk($sformatf("zero%0d_reads", z), longint'(a_q.size()), 0);
      chk($sformatf("zero%0d_results", z), longint'(yrise_q.size()), 0);
      chk($sformatf("zero%0d_pulses", z), longint'(done_cnt), 1);
    end

    // Asynchronous reset in the middle of row 1's issue phase
    load(c1);
    clear_mon();
    start = 1'b1; num_rows = 7'd2; num_cols = 7'd3;
    step();
    start = 1'b0;
    guard = 0;
    while (!(bus.rd_en && bus.a_rd_addr == 12'd4) && guard < 100) begin @(negedge clk); guard++; end
    chk("mid_rst_reach", longint'(guard < 100), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_rd_en", longint'(bus.rd_en), 0);
    chk("mid_rst_aaddr", longint'(bus.a_rd_addr), 0);
    chk("mid_rst_xaddr", longint'(bus.x_rd_addr), 0);
    chk("mid_rst_y_data", longint'(bus.y_data), 0);
    chk("mid_rst_y_index", longint'(bus.y_index), 0);
    chk("mid_rst_y_valid", longint'(bus.y_valid), 0);
    step(); step();
    reset_n = 1'b1;
    step();
    c1.name = "post_rst";
    run_job(c1);

    // Narrow instance: 1x4 of -128 * -128 into a 16-bit accumulator
    start8 = 1'b1; num_rows8 = 7'd1; num_cols8 = 7'd4;
    step();
    start8 = 1'b0;
    guard = 0;
    while (!bus8.y_valid && guard < 100) begin @(negedge clk); guard++; end
    chk("narrow_wait_valid", longint'(guard < 100), 1);
`ifdef MATVEC_MAC_SATURATE_EN
    chk("narrow_y", longint'($signed(bus8.y_data)), 32767);
`else
    chk("narrow_y", longint'($signed(bus8.y_data)), 0);
`endif
    chk("narrow_y_index", longint'(bus8.y_index), 0);
    step(); step();
    chk("narrow_idle", longint'(busy8), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end
endmodule
